// File: rtl/ami_r_pkg.sv
// Shared AXI read widths, burst/response codes and the beat/length records
// stored by the master read block.
package ami_r_pkg;
  localparam int AXI_IW     = 4;
  localparam int AXI_AW     = 32;
  localparam int AXI_LW     = 8;
  localparam int AXI_SW     = 3;
  localparam int AXI_BURSTW = 2;
  localparam int AXI_DW     = 32;
  localparam int AXI_RRESPW = 2;

  localparam logic [AXI_BURSTW-1:0] BT_FIXED = 2'b00;
  localparam logic [AXI_BURSTW-1:0] BT_INCR  = 2'b01;

  localparam logic [AXI_RRESPW-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RRESPW-1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_IW-1:0]     id;
    logic [AXI_DW-1:0]     data;
    logic [AXI_RRESPW-1:0] resp;
    logic                  last;
  } rbeat_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_LW-1:0] len;
  } blen_t;
endpackage

// File: rtl/ami_r_if.sv
// AXI4 read address + read data channels between a master and the interconnect.
interface ami_r_if;
  logic [ami_r_pkg::AXI_IW-1:0]     ARID;
  logic [ami_r_pkg::AXI_AW-1:0]     ARADDR;
  logic [ami_r_pkg::AXI_LW-1:0]     ARLEN;
  logic [ami_r_pkg::AXI_SW-1:0]     ARSIZE;
  logic [ami_r_pkg::AXI_BURSTW-1:0] ARBURST;
  logic                             ARVALID;
  logic                             ARREADY;
  logic [ami_r_pkg::AXI_IW-1:0]     RID;
  logic [ami_r_pkg::AXI_DW-1:0]     RDATA;
  logic [ami_r_pkg::AXI_RRESPW-1:0] RRESP;
  logic                             RLAST;
  logic                             RVALID;
  logic                             RREADY;

  modport mst (output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
               input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID);
  modport slv (input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
               output ARREADY, RID, RDATA, RRESP, RLAST, RVALID);
endinterface

// File: rtl/ami_r_sfifo.sv
// Synchronous FIFO, depth 2**AW, count-based full/empty, async-read head.
module sfifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          wr_ok, rd_ok;

  assign full  = (cnt == DEPTH);
  assign empty = (cnt == '0);
  assign rd_ok = rd && !empty;
  // a full FIFO still takes a write when the head leaves in the same cycle
  assign wr_ok = wr && (!full || rd_ok);
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/ami_r.sv
// AXI4 master read: credit-reserved R buffering so the slave is never stalled.
// AMI_R_RLAST_CHECK_EN: track burst length per AR, derive last and flag protocol errors.
module ami_r import ami_r_pkg::*; #(
  parameter int MST_OD = 4,
  parameter int MST_RD = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  ami_r_if.mst                  axi,
  input  logic [AXI_IW-1:0]     u_arid,
  input  logic [AXI_AW-1:0]     u_araddr,
  input  logic [AXI_LW-1:0]     u_arlen,
  input  logic [AXI_SW-1:0]     u_arsize,
  input  logic [AXI_BURSTW-1:0] u_arburst,
  input  logic                  u_arvalid,
  output logic                  u_arready,
  output logic [AXI_IW-1:0]     u_rid,
  output logic [AXI_DW-1:0]     u_rdata,
  output logic [AXI_RRESPW-1:0] u_rresp,
  output logic                  u_rlast,
  output logic                  u_rvalid,
  input  logic                  u_rready,
  output logic                  u_rbusy,
  output logic                  u_rerr
);
  localparam int ODW = $clog2(MST_OD) + 1;
  localparam int CW  = $clog2(MST_RD) + 1;
  localparam int NW  = (CW > AXI_LW + 1) ? CW : AXI_LW + 1;

  logic [ODW-1:0] od_cnt;
  logic [CW-1:0]  credit;
  logic [NW-1:0]  need;
  logic           acc, r_hs, pop, last_eff, done;
  logic           rff_full, rff_empty;
  rbeat_t         wbeat, hbeat;

  assign need      = NW'(u_arlen) + NW'(1);
  assign u_arready = !ARESET && !axi.ARVALID && (od_cnt < ODW'(MST_OD)) &&
                     (NW'(credit) >= need);
  assign acc       = u_arvalid && u_arready;
  assign axi.RREADY = !ARESET && !rff_full;
  assign r_hs      = axi.RVALID && axi.RREADY;
  assign pop       = u_rready && !rff_empty;
  assign done      = r_hs && last_eff;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      axi.ARVALID <= 1'b0;
      axi.ARID    <= '0;
      axi.ARADDR  <= '0;
      axi.ARLEN   <= '0;
      axi.ARSIZE  <= '0;
      axi.ARBURST <= '0;
    end else if (acc) begin
      axi.ARVALID <= 1'b1;
      axi.ARID    <= u_arid;
      axi.ARADDR  <= u_araddr;
      axi.ARLEN   <= u_arlen;
      axi.ARSIZE  <= u_arsize;
      axi.ARBURST <= u_arburst;
    end else if (axi.ARREADY) begin
      axi.ARVALID <= 1'b0;
    end
  end

  // buffer space for the whole burst is taken at acceptance, returned per pop
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      od_cnt <= '0;
      credit <= CW'(MST_RD);
    end else begin
      od_cnt <= od_cnt + ODW'(acc) - ODW'(done);
      credit <= credit + CW'(pop) - (acc ? need[CW-1:0] : CW'(0));
    end
  end

  assign wbeat = {axi.RID, axi.RDATA, axi.RRESP, last_eff};

  sfifo #(.AW($clog2(MST_RD)), .DW($bits(rbeat_t))) u_rff (
    .clk(ACLK), .rst(ARESET), .wr(r_hs), .wdata(wbeat), .rd(pop),
    .rdata(hbeat), .full(rff_full), .empty(rff_empty)
  );

  assign u_rid    = hbeat.id;
  assign u_rdata  = hbeat.data;
  assign u_rresp  = hbeat.resp;
  assign u_rlast  = hbeat.last;
  assign u_rvalid = !rff_empty;
  assign u_rbusy  = (od_cnt != '0);

`ifdef AMI_R_RLAST_CHECK_EN
  blen_t             lf_w, lf_h;
  logic              lf_full, lf_empty, rerr;
  logic [AXI_LW-1:0] bcnt;

  assign lf_w = {axi.ARID, axi.ARLEN};

  sfifo #(.AW($clog2(MST_OD)), .DW($bits(blen_t))) u_lff (
    .clk(ACLK), .rst(ARESET), .wr(axi.ARVALID && axi.ARREADY && !lf_full),
    .wdata(lf_w), .rd(done), .rdata(lf_h), .full(lf_full), .empty(lf_empty)
  );

  assign last_eff = (bcnt == lf_h.len);
  assign u_rerr   = rerr;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      bcnt <= '0;
      rerr <= 1'b0;
    end else if (r_hs) begin
      bcnt <= last_eff ? '0 : bcnt + 1'b1;
      if (lf_empty || (axi.RLAST != last_eff) || (axi.RID != lf_h.id)) rerr <= 1'b1;
    end
  end
`else
  assign last_eff = axi.RLAST;
  assign u_rerr   = 1'b0;
`endif
endmodule

// File: tb/tb_ami_r.sv
// Directed bench for ami_r: bench-side AXI slave, queue-based reference model
// checked every cycle, plus literal expectations at the key points.
module tb_ami_r;
  import ami_r_pkg::*;

  localparam int OD = 4;
  localparam int RD = 16;

  logic clk, rst;
  logic [AXI_IW-1:0]     u_arid;
  logic [AXI_AW-1:0]     u_araddr;
  logic [AXI_LW-1:0]     u_arlen;
  logic [AXI_SW-1:0]     u_arsize;
  logic [AXI_BURSTW-1:0] u_arburst;
  logic                  u_arvalid, u_arready;
  logic [AXI_IW-1:0]     u_rid;
  logic [AXI_DW-1:0]     u_rdata;
  logic [AXI_RRESPW-1:0] u_rresp;
  logic                  u_rlast, u_rvalid, u_rready, u_rbusy, u_rerr;

  ami_r_if bus();

  ami_r #(.MST_OD(OD), .MST_RD(RD)) dut (
    .ACLK(clk), .ARESET(rst), .axi(bus),
    .u_arid(u_arid), .u_araddr(u_araddr), .u_arlen(u_arlen), .u_arsize(u_arsize),
    .u_arburst(u_arburst), .u_arvalid(u_arvalid), .u_arready(u_arready),
    .u_rid(u_rid), .u_rdata(u_rdata), .u_rresp(u_rresp), .u_rlast(u_rlast),
    .u_rvalid(u_rvalid), .u_rready(u_rready), .u_rbusy(u_rbusy), .u_rerr(u_rerr)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // ---------------- bench slave ----------------
  typedef struct { logic [AXI_IW-1:0] id; logic [AXI_AW-1:0] addr; int len; } sar_t;
  sar_t sq[$];
  int   sb = 0;
  int   rcv_cnt = 0;
  int   bad_idx = -1;
  bit   r_en = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      sq.delete();
      sb = 0;
    end else begin
      if (bus.RVALID && bus.RREADY) begin
        rcv_cnt++;
        if (sb == sq[0].len) begin sq.pop_front(); sb = 0; end
        else sb++;
      end
      if (bus.ARVALID && bus.ARREADY)
        sq.push_back('{id: bus.ARID, addr: bus.ARADDR, len: int'(bus.ARLEN)});
    end
    #1;
    bus.RVALID = r_en && (sq.size() > 0);
    if (sq.size() > 0) begin
      bus.RID   = sq[0].id;
      bus.RDATA = sq[0].addr + 32'(sb);
      bus.RRESP = sb[0] ? RESP_SLVERR : RESP_OKAY;
      bus.RLAST = (sb == sq[0].len) || (sb == bad_idx);
    end else begin
      bus.RID = '0; bus.RDATA = '0; bus.RRESP = '0; bus.RLAST = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  bit                    started = 1'b0;
  bit                    m_arv, m_err;
  logic [AXI_IW-1:0]     m_arid;
  logic [AXI_AW-1:0]     m_araddr;
  logic [AXI_LW-1:0]     m_arlen;
  logic [AXI_SW-1:0]     m_arsize;
  logic [AXI_BURSTW-1:0] m_arburst;
  int                    m_cred, m_od;
  rbeat_t                m_q[$];
  bit                    acc, arhs, rhs, pop, last;
`ifdef AMI_R_RLAST_CHECK_EN
  typedef struct { logic [AXI_IW-1:0] id; int len; } ml_t;
  ml_t m_lq[$];
  int  m_bc;
`endif

  function automatic bit exp_ardy();
    return !rst && !m_arv && (m_od < OD) && (m_cred >= int'(u_arlen) + 1);
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_arv = 0; m_err = 0; m_cred = RD; m_od = 0; m_q.delete();
      m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
`ifdef AMI_R_RLAST_CHECK_EN
      m_lq.delete(); m_bc = 0;
`endif
    end else begin
      acc  = u_arvalid && exp_ardy();
      arhs = m_arv && bus.ARREADY;
      rhs  = bus.RVALID && (m_q.size() < RD);
      pop  = (m_q.size() > 0) && u_rready;
      last = bus.RLAST;
`ifdef AMI_R_RLAST_CHECK_EN
      if (rhs) begin
        if (m_lq.size() == 0) m_err = 1;
        else begin
          last = (m_bc == m_lq[0].len);
          if ((bus.RLAST != last) || (bus.RID != m_lq[0].id)) m_err = 1;
          if (last) begin m_lq.pop_front(); m_bc = 0; end
          else m_bc++;
        end
      end
      if (arhs) m_lq.push_back('{id: m_arid, len: int'(m_arlen)});
`endif
      if (pop) void'(m_q.pop_front());
      if (rhs) m_q.push_back('{id: bus.RID, data: bus.RDATA, resp: bus.RRESP, last: last});
      m_cred = m_cred + (pop ? 1 : 0) - (acc ? int'(u_arlen) + 1 : 0);
      m_od   = m_od + (acc ? 1 : 0) - ((rhs && last) ? 1 : 0);
      if (acc) begin
        m_arv = 1; m_arid = u_arid; m_araddr = u_araddr; m_arlen = u_arlen;
        m_arsize = u_arsize; m_arburst = u_arburst;
      end else if (arhs) m_arv = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("arvalid", bus.ARVALID, m_arv);
      chk("ar_payload", {bus.ARID, bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST},
          {m_arid, m_araddr, m_arlen, m_arsize, m_arburst});
      chk("rready", bus.RREADY, !rst && (m_q.size() < RD));
      chk("u_arready", u_arready, exp_ardy());
      chk("u_rvalid", u_rvalid, m_q.size() > 0);
      chk("u_rbusy", u_rbusy, m_od != 0);
      chk("u_rerr", u_rerr, m_err);
      if (m_q.size() > 0)
        chk("u_r_head", {u_rid, u_rdata, u_rresp, u_rlast},
            {m_q[0].id, m_q[0].data, m_q[0].resp, m_q[0].last});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [AXI_IW-1:0] id, input logic [AXI_AW-1:0] a,
                       input logic [AXI_LW-1:0] l);
    bit hs = 1'b0;
    u_arid = id; u_araddr = a; u_arlen = l; u_arsize = 3'd2; u_arburst = BT_INCR;
    u_arvalid = 1'b1;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk); hs = u_arready;
      step();
    end
    u_arvalid = 1'b0;
    chk("issue_accept", hs, 1);
  endtask

  task automatic wait_idle(input string n);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); ok = !u_rbusy;
    end
    chk(n, ok, 1);
  endtask

  task automatic drain(input string n);
    bit ok = 1'b0;
    step(); u_rready = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); ok = !u_rvalid && !u_rbusy;
      if (!ok) step();
    end
    chk(n, ok, 1);
    step(); u_rready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  int base;
  bit ok;

  initial begin
    rst = 1'b1; u_arvalid = 0; u_arid = '0; u_araddr = '0; u_arlen = '0;
    u_arsize = '0; u_arburst = '0; u_rready = 0; bus.ARREADY = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", bus.ARVALID, 0);
    chk("rst_payload", {bus.ARID, bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST}, 0);
    chk("rst_rready", bus.RREADY, 0);
    chk("rst_uarready", u_arready, 0);
    chk("rst_urvalid", u_rvalid, 0);
    chk("rst_urbusy", u_rbusy, 0);
    chk("rst_urerr", u_rerr, 0);
    step(); rst = 1'b0;

    // single burst, ARREADY immediate
    bus.ARREADY = 1'b1;
    issue(4'h1, 32'h100, 8'd3);
    @(negedge clk); chk("sb_arvalid_hi", bus.ARVALID, 1); chk("sb_araddr", bus.ARADDR, 32'h100);
    @(negedge clk); chk("sb_arvalid_lo", bus.ARVALID, 0);
    wait_idle("sb_idle");
    chk("sb_buffered", u_rvalid, 1);
    step(); u_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sb_data", u_rdata, 32'h100 + 32'(i));
      chk("sb_last", u_rlast, i == 3);
      chk("sb_resp", u_rresp, (i % 2) ? RESP_SLVERR : RESP_OKAY);
      step();
    end
    u_rready = 1'b0; u_arlen = 8'd15;
    @(negedge clk); chk("sb_credit_back", u_arready, 1); chk("sb_empty", u_rvalid, 0);
    step();

    // outstanding limit: slave withholds R
    r_en = 1'b0;
    for (int i = 0; i < 4; i++) issue(4'(i), 32'h200 + 32'(i * 16), 8'd0);
    u_arid = 4'h5; u_araddr = 32'h300; u_arlen = 8'd0; u_arvalid = 1'b1;
    repeat (8) begin @(negedge clk); chk("od_limit", u_arready, 0); step(); end
    r_en = 1'b1;
    issue(4'h5, 32'h300, 8'd0);
    wait_idle("od_idle");
    drain("od_drain");

    // credit stall: 8 beats held, a 9-beat burst needs one pop
    issue(4'h7, 32'h400, 8'd7);
    wait_idle("cs_idle");
    step();
    u_arid = 4'h8; u_araddr = 32'h500; u_arlen = 8'd8; u_arvalid = 1'b1;
    repeat (5) begin @(negedge clk); chk("cs_stall", u_arready, 0); step(); end
    u_rready = 1'b1; step(); u_rready = 1'b0;
    @(negedge clk); chk("cs_release", u_arready, 1);
    step(); u_arvalid = 1'b0;
    wait_idle("cs_idle2");
    drain("cs_drain");

    // back-pressure: full-depth burst while the user stalls
    base = rcv_cnt;
    issue(4'h9, 32'h600, 8'd15);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rcv_cnt - base < 16) chk("bp_rready", bus.RREADY, 1);
    end
    chk("bp_count", rcv_cnt - base, 16);
    chk("bp_full", bus.RREADY, 0);
    chk("bp_busy", u_rbusy, 0);
    drain("bp_drain");

`ifdef AMI_R_RLAST_CHECK_EN
    bad_idx = 1;
    issue(4'hA, 32'h700, 8'd3);
    wait_idle("rc_idle");
    chk("rc_err", u_rerr, 1);
    step(); bad_idx = -1; u_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("rc_last", u_rlast, i == 3); step();
    end
    u_rready = 1'b0;
    @(negedge clk); chk("rc_held", u_rerr, 1);
`else
    @(negedge clk); chk("rc_off", u_rerr, 0);
`endif
    step();

    // reset mid-burst after two beats
    base = rcv_cnt;
    issue(4'hB, 32'h800, 8'd7);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin step(); ok = (rcv_cnt - base >= 2); end
    chk("rm_two", rcv_cnt - base, 2);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rm_arvalid", bus.ARVALID, 0);
    chk("rm_payload", {bus.ARID, bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST}, 0);
    chk("rm_rready", bus.RREADY, 0);
    chk("rm_uarready", u_arready, 0);
    chk("rm_urvalid", u_rvalid, 0);
    chk("rm_urbusy", u_rbusy, 0);
    chk("rm_urerr", u_rerr, 0);
    step(); rst = 1'b0; u_arlen = 8'd15;
    @(negedge clk); chk("rm_credit", u_arready, 1);
    step();

    issue(4'hC, 32'h900, 8'd1);
    wait_idle("fin_idle");
    drain("fin_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
